mcp4728_update_scheduler: RTL and testbench
===========================================

Name: mcp4728_update_scheduler

Overview:
- Upstream feeder for the mcp4728 I2C DAC controller.
- Holds a 4-chip x 4-channel shadow bank of 12-bit setpoints, written by a host/sequencer port, with one dirty flag per chip.
- Round-robin selects a dirty chip and presents its four values plus the chip number on the controller's dac0..dac3/dacNumber inputs.
- Holds needTransmit until the controller reports frame completion. Runs in the controller's clock domain (200 kHz or lower).

Parameters:
- NUM_CHIPS, 4, number of mcp4728 devices (LDAC lines); valid range 1..4.
- TIMEOUT, 4095, clk cycles allowed in WAIT before a frame is abandoned.

Ports:
- clk  in  1  controller clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scheduler may start new frames.
- wr_en  in  1  one-cycle write strobe; always accepted, no back-pressure.
- wr_chip  in  2  target chip 0..NUM_CHIPS-1; writes to chip >= NUM_CHIPS are ignored.
- wr_ch  in  2  target channel 0..3.
- wr_data  in  12  setpoint 0..4095.
- tx_done  in  1  one-cycle pulse from the controller when the current frame completes.
- err_clr  in  1  clears timeout_err.
- dac0, dac1, dac2, dac3  out  12 each  latched values for the chip being sent.
- dacNumber  out  3  chip index being sent.
- needTransmit  out  1  frame request to the controller.
- busy  out  1  high in LOAD or WAIT.
- pending  out  4  per-chip dirty flags; bits >= NUM_CHIPS are 0.
- timeout_err  out  1  sticky; set on frame timeout.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; bank all 0; pending 0; dac0..3 0; dacNumber 0; needTransmit 0; busy 0; timeout_err 0; rr pointer 0; timeout counter 0.
  - Reset during WAIT drops needTransmit immediately and abandons the frame.
- Write: on wr_en, bank[wr_chip][wr_ch] <= wr_data and pending[wr_chip] <= 1, both visible the next cycle.
- States: IDLE, LOAD, WAIT.
- IDLE:
  - If enable=1 and pending != 0, pick the first set pending bit searching from rr pointer upward, wrapping modulo NUM_CHIPS.
  - Go to LOAD with sel = that chip.
- LOAD (exactly 1 cycle):
  - dac0..3 <= bank[sel][0..3] as registered before this cycle's write.
  - dacNumber <= sel; pending[sel] <= 0; rr <= sel+1 mod NUM_CHIPS.
  - needTransmit <= 1; timeout counter <= 0; go to WAIT.
  - Latency: pending bit set at cycle N -> LOAD at N+1 -> needTransmit high from N+2.
- WAIT:
  - needTransmit held 1; dac0..3 and dacNumber held stable.
  - tx_done=1: needTransmit <= 0, go to IDLE. The next frame's needTransmit rises no earlier than 3 cycles later, giving at least 2 low cycles between frames.
  - No tx_done and counter reaches TIMEOUT-1: needTransmit <= 0, timeout_err <= 1, pending[sel] <= 1 (re-queue), go to IDLE.
  - Otherwise counter increments.
  - tx_done outside WAIT is ignored.
- Simultaneous events:
  - wr_en to sel in the LOAD cycle: write wins; pending[sel] stays 1 and the chip is re-sent later with the new value.
  - Writes to sel during WAIT: update the bank and set pending; the in-flight frame outputs are unchanged.
  - err_clr and a timeout in the same cycle: set wins.
  - enable=0 in LOAD or WAIT: the current frame completes; no new LOAD.
- Fairness: with all chips constantly dirty, frames go 0,1,2,3,0,...; no chip waits more than NUM_CHIPS-1 frames.

Test Plan:
- After reset release: write chip2 ch0..3 = 512/1024/2048/4095, enable=1.
  - Required: needTransmit rises 2 cycles after the last write; dacNumber=2; dac0..3=512/1024/2048/4095.
  - Pulse tx_done 10 cycles later: needTransmit falls the next cycle; pending=0.
- Write one value to each of chips 0..3 in consecutive cycles; answer each frame with tx_done after 5 cycles.
  - Required: dacNumber sequence 0,1,2,3.
  - Then re-dirty chips 1 and 3 with rr=0: order 1,3.
- Rewrite chip1 ch2=100 during chip1's WAIT.
  - Required: in-flight dac2 unchanged; after tx_done a second chip1 frame is sent with dac2=100.
- TIMEOUT=16, no tx_done.
  - Required: needTransmit drops after 16 WAIT cycles; timeout_err=1; chip re-sent next.
  - err_clr clears timeout_err.
- Assert rst low mid-WAIT.
  - Required: needTransmit=0 and all outputs 0 asynchronously; no frame after release until a new write.
- enable=0 with pending=4'b0101.
  - Required: no needTransmit.
  - Then set enable=1: chip0 is sent first, then chip2.

Source files
------------

// File: rtl/mcp4728_update_scheduler.sv
// Shadow bank of per-chip DAC setpoints; round-robin picks a dirty chip and requests one controller frame.
// needTransmit rises two cycles after a chip goes dirty and holds until tx_done or the WAIT timeout.
module mcp4728_update_scheduler #(
  parameter int NUM_CHIPS = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [1:0]  wr_chip,
  input  logic [1:0]  wr_ch,
  input  logic [11:0] wr_data,
  input  logic        tx_done,
  input  logic        err_clr,
  output logic [11:0] dac0,
  output logic [11:0] dac1,
  output logic [11:0] dac2,
  output logic [11:0] dac3,
  output logic [2:0]  dacNumber,
  output logic        needTransmit,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        timeout_err
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [11:0]   bank_q [4][4];
  logic [3:0]    pending_q, pending_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   dac_q [4];
  logic [11:0]   dac_d [4];
  logic [2:0]    num_q, num_d;
  logic          nt_q, nt_d;
  logic          err_q, err_d;
  logic          wr_ok;
  logic          pick_vld;
  logic [1:0]    pick_idx;
  logic [1:0]    cand;

  assign wr_ok = wr_en && (int'(wr_chip) < NUM_CHIPS);

  // Scan downward so the candidate closest to the rr pointer is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    cand     = 2'd0;
    for (int i = NUM_CHIPS - 1; i >= 0; i--) begin
      cand = 2'((int'(rr_q) + i) % NUM_CHIPS);
      if (pending_q[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    dac_d     = dac_q;
    num_d     = num_q;
    nt_d      = nt_q;
    err_d     = err_clr ? 1'b0 : err_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && pick_vld) begin
          sel_d   = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int c = 0; c < 4; c++) dac_d[c] = bank_q[sel_q][c];
        num_d            = {1'b0, sel_q};
        pending_d[sel_q] = 1'b0;
        rr_d             = 2'((int'(sel_q) + 1) % NUM_CHIPS);
        nt_d             = 1'b1;
        cnt_d            = '0;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          nt_d    = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          nt_d             = 1'b0;
          err_d            = 1'b1;
          pending_d[sel_q] = 1'b1;
          state_d          = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A write in the LOAD cycle overrides the clear so the chip is re-sent with the new value.
    if (wr_ok) pending_d[wr_chip] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bank_q    <= '{default: '0};
      pending_q <= '0;
      sel_q     <= '0;
      rr_q      <= '0;
      cnt_q     <= '0;
      dac_q     <= '{default: '0};
      num_q     <= '0;
      nt_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      dac_q     <= dac_d;
      num_q     <= num_d;
      nt_q      <= nt_d;
      err_q     <= err_d;
      if (wr_ok) bank_q[wr_chip][wr_ch] <= wr_data;
    end
  end

  assign dac0         = dac_q[0];
  assign dac1         = dac_q[1];
  assign dac2         = dac_q[2];
  assign dac3         = dac_q[3];
  assign dacNumber    = num_q;
  assign needTransmit = nt_q;
  assign busy         = (state_q != S_IDLE);
  assign pending      = pending_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_mcp4728_update_scheduler.sv
// Bench for mcp4728_update_scheduler: directed frame sequences plus random traffic against a cycle-level reference.
module tb_mcp4728_update_scheduler;
  localparam int NC = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, wr_en, tx_done, err_clr;
  logic [1:0]  wr_chip, wr_ch;
  logic [11:0] wr_data;
  logic [11:0] dac0, dac1, dac2, dac3;
  logic [2:0]  dacNumber;
  logic        needTransmit, busy, timeout_err;
  logic [3:0]  pending;

  int checks = 0;
  int errors = 0;

  mcp4728_update_scheduler #(.NUM_CHIPS(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_chip(wr_chip), .wr_ch(wr_ch),
    .wr_data(wr_data), .tx_done(tx_done), .err_clr(err_clr), .dac0(dac0), .dac1(dac1),
    .dac2(dac2), .dac3(dac3), .dacNumber(dacNumber), .needTransmit(needTransmit), .busy(busy),
    .pending(pending), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference: frame-level view (in_frame, age since frame start) of the scheduler rules.
  int         m_bank [4][4];
  logic [3:0] m_pend;
  int         m_rr, m_cur, m_age, m_num;
  bit         m_in, m_nt, m_err;
  int         m_dac [4];

  typedef struct {
    logic [1:0]  chip;
    logic [11:0] data;
    logic [2:0]  exp_num;
    logic [11:0] exp_dac0;
  } frame_vec_t;
  frame_vec_t vec [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      for (int h = 0; h < 4; h++) m_bank[c][h] = 0;
      m_dac[c] = 0;
    end
    m_pend = '0; m_rr = 0; m_cur = 0; m_age = 0; m_num = 0;
    m_in = 0; m_nt = 0; m_err = 0;
  endtask

  function automatic int m_pick();
    for (int i = 0; i < NC; i++) if (m_pend[(m_rr + i) % NC]) return (m_rr + i) % NC;
    return 0;
  endfunction

  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    if (err_clr) m_err = 0;
    if (!m_in) begin
      if (enable && m_pend != 4'b0) begin
        m_in = 1; m_age = 0; m_cur = m_pick();
      end
    end else if (m_age == 0) begin
      for (int h = 0; h < 4; h++) m_dac[h] = m_bank[m_cur][h];
      m_num = m_cur; m_pend[m_cur] = 1'b0; m_rr = (m_cur + 1) % NC;
      m_nt = 1; m_age = 1;
    end else if (tx_done) begin
      m_nt = 0; m_in = 0;
    end else if (m_age == TO) begin
      m_nt = 0; m_in = 0; m_err = 1; m_pend[m_cur] = 1'b1;
    end else begin
      m_age++;
    end
    if (wr_en && int'(wr_chip) < NC) begin
      m_bank[wr_chip][wr_ch] = int'(wr_data);
      m_pend[wr_chip] = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("ref needTransmit", needTransmit, m_nt);
    check("ref busy", busy, m_in);
    check("ref dacNumber", dacNumber, m_num);
    check("ref dac0", dac0, m_dac[0]);
    check("ref dac1", dac1, m_dac[1]);
    check("ref dac2", dac2, m_dac[2]);
    check("ref dac3", dac3, m_dac[3]);
    check("ref pending", pending, m_pend);
    check("ref timeout_err", timeout_err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic write(input int chip, input int ch, input int data);
    wr_en = 1'b1; wr_chip = 2'(chip); wr_ch = 2'(ch); wr_data = 12'(data);
    tick();
    wr_en = 1'b0;
  endtask

  function automatic logic [11:0] dac_at(input int idx);
    case (idx)
      0: return dac0;
      1: return dac1;
      2: return dac2;
      default: return dac3;
    endcase
  endfunction

  task automatic wait_nt(input string name);
    int n;
    n = 0;
    while (needTransmit !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check(name, needTransmit, 1);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("needTransmit falls after tx_done", needTransmit, 0);
  endtask

  task automatic serve_frame(input int exp_num, input int idx, input int exp_val, input int hold);
    wait_nt("frame request");
    check("frame dacNumber", dacNumber, exp_num);
    check("frame dac value", dac_at(idx), exp_val);
    repeat (hold) tick();
    pulse_done();
  endtask

  initial begin
    int n;
    vec[0] = '{chip: 2'd0, data: 12'd101, exp_num: 3'd0, exp_dac0: 12'd101};
    vec[1] = '{chip: 2'd1, data: 12'd202, exp_num: 3'd1, exp_dac0: 12'd202};
    vec[2] = '{chip: 2'd2, data: 12'd303, exp_num: 3'd2, exp_dac0: 12'd303};
    vec[3] = '{chip: 2'd3, data: 12'd404, exp_num: 3'd3, exp_dac0: 12'd404};

    rst = 1'b0; enable = 1'b0; wr_en = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
    wr_chip = '0; wr_ch = '0; wr_data = '0;
    model_reset();
    repeat (2) tick();
    check("reset needTransmit", needTransmit, 0);
    check("reset busy", busy, 0);
    check("reset pending", pending, 0);
    check("reset dacNumber", dacNumber, 0);
    check("reset dac3", dac3, 0);
    rst = 1'b1;
    tick();

    // Four writes to chip 2, then enable: request two cycles after the last write.
    write(2, 0, 512); write(2, 1, 1024); write(2, 2, 2048); write(2, 3, 4095);
    enable = 1'b1;
    tick();
    check("t1 needTransmit one cycle after write", needTransmit, 0);
    tick();
    check("t1 needTransmit two cycles after write", needTransmit, 1);
    check("t1 dacNumber", dacNumber, 2);
    check("t1 dac0", dac0, 512);
    check("t1 dac1", dac1, 1024);
    check("t1 dac2", dac2, 2048);
    check("t1 dac3", dac3, 4095);
    repeat (9) tick();
    pulse_done();
    check("t1 pending after frame", pending, 0);

    // One write per chip back to back; frames must come out 0,1,2,3.
    for (int k = 0; k < 4; k++) write(vec[k].chip, 0, vec[k].data);
    for (int k = 0; k < 4; k++) serve_frame(vec[k].exp_num, 0, vec[k].exp_dac0, 4);

    // rr is back at 0: chips 3 and 1 dirty must go 1 then 3.
    enable = 1'b0;
    write(3, 0, 333); write(1, 0, 111);
    enable = 1'b1;
    serve_frame(1, 0, 111, 4);
    serve_frame(3, 0, 333, 4);

    // Rewrite during WAIT: in-flight frame unchanged, chip re-sent with the new value.
    write(1, 2, 777);
    wait_nt("t3 first frame");
    check("t3 first dacNumber", dacNumber, 1);
    check("t3 first dac2", dac2, 777);
    repeat (2) tick();
    write(1, 2, 100);
    check("t3 in-flight dac2", dac2, 777);
    check("t3 chip1 re-dirtied", pending[1], 1);
    tick();
    pulse_done();
    serve_frame(1, 2, 100, 3);

    // Timeout: request held for TO WAIT cycles, sticky error, chip re-sent.
    write(3, 0, 55);
    wait_nt("t4 frame");
    check("t4 dacNumber", dacNumber, 3);
    n = 0;
    while (needTransmit === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("t4 cycles needTransmit held", n, TO);
    check("t4 timeout_err set", timeout_err, 1);
    check("t4 chip3 requeued", pending[3], 1);
    serve_frame(3, 0, 55, 2);
    check("t4 timeout_err still sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4 err_clr clears", timeout_err, 0);

    // Asynchronous reset in the middle of WAIT.
    write(0, 1, 9);
    wait_nt("t5 frame");
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check("t5 async needTransmit", needTransmit, 0);
    check("t5 async busy", busy, 0);
    check("t5 async dacNumber", dacNumber, 0);
    check("t5 async dac1", dac1, 0);
    check("t5 async pending", pending, 0);
    model_reset();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t5 no frame after release", needTransmit, 0);
    end

    // enable low holds off pending 0101; enabling sends chip 0 then chip 2.
    enable = 1'b0;
    write(2, 0, 22); write(0, 0, 11);
    repeat (5) tick();
    check("t6 pending 0101", pending, 4'b0101);
    check("t6 no request while disabled", needTransmit, 0);
    enable = 1'b1;
    serve_frame(0, 0, 11, 2);
    serve_frame(2, 0, 22, 2);

    // Random traffic against the reference.
    for (int k = 0; k < 1500; k++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_chip = 2'($urandom_range(0, 3));
      wr_ch   = 2'($urandom_range(0, 3));
      wr_data = 12'($urandom_range(0, 4095));
      enable  = ($urandom_range(0, 9) < 8);
      err_clr = ($urandom_range(0, 9) == 0);
      tx_done = needTransmit ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 19) == 0);
      tick();
    end
    wr_en = 1'b0; tx_done = 1'b0; err_clr = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
